// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the byte-serial RAM/IO port controller.
package memory_controller_pkg;

  typedef logic [31:0] addr_type_t;
  typedef logic [31:0] inst_type_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    MC_IDLE     = 2'd0,
    MC_IF_READ  = 2'd1,
    MC_LS_READ  = 2'd2,
    MC_LS_WRITE = 2'd3
  } mc_state_t;

  // len 2'b11 is deliberately folded into the word case
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller.sv
// Owns the byte-wide RAM/IO port: arbitrates fetch vs load/store and runs each
// transfer as a byte-serial read or write sequence with a single done pulse.
module memory_controller #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [1:0] IO_SEL     = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_flag,
  input  logic                  if_to_mc_ready,
  input  logic [ADDR_WIDTH-1:0] if_to_mc_PC,
  output logic                  mc_to_if_ready,
  output logic [DATA_WIDTH-1:0] mc_to_if_inst,
  input  logic                  lsb_to_mc_ready,
  input  logic                  lsb_to_mc_wr,
  input  logic [1:0]            lsb_to_mc_len,
  input  logic [ADDR_WIDTH-1:0] lsb_to_mc_addr,
  input  logic [DATA_WIDTH-1:0] lsb_to_mc_data,
  output logic                  mc_to_lsb_ready,
  output logic [DATA_WIDTH-1:0] mc_to_lsb_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);
  import memory_controller_pkg::*;

  mc_state_t             state_reg, state_next;
  logic [2:0]            cnt_reg, n_reg;
  logic [ADDR_WIDTH-1:0] mem_a_reg;
  logic [7:0]            mem_dout_reg;
  logic                  io_space_reg;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next, buf_reg, buf_merged;
  logic [DATA_WIDTH-1:0] if_inst_reg, lsb_data_reg;
  logic                  if_ready_reg, lsb_ready_reg;

  logic can_accept, take_lsb, take_if, rd_active, rd_done, io_stall, wr_step, wr_last;

  // A requester is not re-accepted on its own pulse cycle; the other one may be.
  assign can_accept = (state_reg == MC_IDLE) && !clear_flag;
  assign take_lsb   = can_accept && lsb_to_mc_ready && !lsb_ready_reg;
  assign take_if    = can_accept && !take_lsb && if_to_mc_ready && !if_ready_reg;
  assign rd_active  = (state_reg == MC_IF_READ) || (state_reg == MC_LS_READ);
  assign rd_done    = rd_active && !clear_flag && (cnt_reg == n_reg);
  assign io_stall   = io_space_reg && io_buffer_full;
  assign wr_step    = (state_reg == MC_LS_WRITE) && !io_stall;
  assign wr_last    = wr_step && (cnt_reg == n_reg - 3'd1);
  assign wdata_next = wdata_reg >> 8;

  // Byte i of the read result arrives while cnt_reg == i+1
  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_byte
    assign buf_merged[8*gi +: 8] = (cnt_reg == 3'(gi + 1)) ? mem_din : buf_reg[8*gi +: 8];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      state_reg <= MC_IDLE;
    else if (rdy_in) state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MC_IDLE: begin
        if (take_lsb)     state_next = lsb_to_mc_wr ? MC_LS_WRITE : MC_LS_READ;
        else if (take_if) state_next = MC_IF_READ;
      end
      MC_IF_READ, MC_LS_READ: begin
        if (clear_flag || rd_done) state_next = MC_IDLE;
      end
      MC_LS_WRITE: begin
        if (wr_last) state_next = MC_IDLE;
      end
      default: state_next = MC_IDLE;
    endcase
  end

  always_comb begin
    mem_wr = 1'b0;
    if (rdy_in && state_reg == MC_LS_WRITE && !io_stall) mem_wr = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_a_reg     <= '0;
      mem_dout_reg  <= '0;
      io_space_reg  <= 1'b0;
      cnt_reg       <= '0;
      n_reg         <= '0;
      wdata_reg     <= '0;
      buf_reg       <= '0;
      if_inst_reg   <= '0;
      lsb_data_reg  <= '0;
      if_ready_reg  <= 1'b0;
      lsb_ready_reg <= 1'b0;
    end else if (rdy_in) begin
      if_ready_reg  <= 1'b0;
      lsb_ready_reg <= 1'b0;
      if (take_lsb || take_if) begin
        mem_a_reg    <= take_lsb ? lsb_to_mc_addr : if_to_mc_PC;
        io_space_reg <= take_lsb && (lsb_to_mc_addr[17:16] == IO_SEL);
        n_reg        <= take_lsb ? len_to_bytes(lsb_to_mc_len) : len_to_bytes(LEN_WORD);
        cnt_reg      <= '0;
        buf_reg      <= '0;
        wdata_reg    <= lsb_to_mc_data;
        if (take_lsb && lsb_to_mc_wr) mem_dout_reg <= lsb_to_mc_data[7:0];
      end else if (rd_active && !clear_flag) begin
        buf_reg <= buf_merged;
        cnt_reg <= cnt_reg + 3'd1;
        if (cnt_reg + 3'd1 < n_reg) mem_a_reg <= mem_a_reg + ADDR_WIDTH'(1);
        if (rd_done) begin
          if (state_reg == MC_IF_READ) begin
            if_inst_reg  <= buf_merged;
            if_ready_reg <= 1'b1;
          end else begin
            lsb_data_reg  <= buf_merged;
            lsb_ready_reg <= 1'b1;
          end
        end
      end else if (wr_step) begin
        if (wr_last) begin
          lsb_ready_reg <= 1'b1;
        end else begin
          mem_a_reg    <= mem_a_reg + ADDR_WIDTH'(1);
          mem_dout_reg <= wdata_next[7:0];
          wdata_reg    <= wdata_next;
          cnt_reg      <= cnt_reg + 3'd1;
        end
      end
    end
  end

  assign mem_a           = mem_a_reg;
  assign mem_dout        = mem_dout_reg;
  assign mc_to_if_ready  = if_ready_reg;
  assign mc_to_if_inst   = if_inst_reg;
  assign mc_to_lsb_ready = lsb_ready_reg;
  assign mc_to_lsb_data  = lsb_data_reg;

endmodule
